// File: rtl/bike_pkg.sv
// Shared types and constants for the bike-computer datapath blocks.
// Holds the divider-client FSM states, the default unit scale and the divider widths.
package bike_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  localparam int SCALE_DEF = 3600;
  localparam int DIV_WD    = 16;
endpackage

// File: rtl/avg_speed_div_client.sv
// Divider handshake: launch pulse in LAUNCH once the divider is free, completion in WAIT.
// Optional watchdog under AVG_SPEED_TIMEOUT_EN ends WAIT after TMO cycles with no quotient.
module avg_speed_div_client
  import bike_pkg::*;
`ifdef AVG_SPEED_TIMEOUT_EN
#(
  parameter int TMO = 255
)
`endif
(
`ifdef AVG_SPEED_TIMEOUT_EN
  input  logic   clk,
  input  logic   r,
`endif
  input  state_t state_i,
  input  logic   zero_i,
  input  logic   div_busy,
  input  logic   div_ready,
  output logic   div_start,
  output logic   done_o,
  output logic   tmo_o
);
  // A zero divisor never reaches the divider; the owner routes LAUNCH straight to DONE.
  assign div_start = (state_i == LAUNCH) && !zero_i && !div_busy;
  // Readiness is only honoured in WAIT, so a quotient seen in the launch cycle is dropped.
  assign done_o    = (state_i == WAIT) && div_ready;

`ifdef AVG_SPEED_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (r || state_i != WAIT) begin
      cnt_q <= '0;
    end else if (!div_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_o = (state_i == WAIT) && !div_ready && (cnt_q == CW'(TMO - 1));
`else
  assign tmo_o = 1'b0;
`endif
endmodule

// File: rtl/avg_speed_calc.sv
// Average speed = trip_distance*SCALE / trip_time via the shared divider, saturated to WO bits.
// One request queued while busy; AVG_SPEED_TIMEOUT_EN adds a divider watchdog and tmo_err.
module avg_speed_calc
  import bike_pkg::*;
#(
  parameter int WD    = DIV_WD,
  parameter int WO    = 12,
  parameter int SCALE = SCALE_DEF
`ifdef AVG_SPEED_TIMEOUT_EN
  , parameter int TMO = 255
`endif
) (
  input  logic            clk,
  input  logic            r,
  input  logic            en,
  input  logic            get,
  input  logic [WD-1:0]   trip_time,
  input  logic [WD-1:0]   trip_distance,
  output logic [WO-1:0]   out,
  output logic            valid,
  output logic            sat,
  output logic            zero_t,
  input  logic            div_busy,
  input  logic            div_ready,
  input  logic [2*WD-1:0] div_quot,
  output logic            div_start,
  output logic [2*WD-1:0] div_dividend,
  output logic [WD-1:0]   div_divisor
`ifdef AVG_SPEED_TIMEOUT_EN
  , output logic          tmo_err
`endif
);
  localparam logic [2*WD-1:0] QMAX = (2*WD)'((1 << WO) - 1);

  state_t            state_q;
  logic              pend_q;
  logic [2*WD-1:0]   dvd_q, qdvd_q;
  logic [WD-1:0]     dvs_q, qdvs_q;
  logic [WO-1:0]     out_q;
  logic              valid_q, sat_q, zero_q;
  logic [2*WD-1:0]   dividend_d;
  logic              acc, done, tmo, quot_sat;

  assign dividend_d = (2*WD)'(trip_distance) * (2*WD)'(SCALE);
  assign acc        = get & en;
  assign quot_sat   = div_quot > QMAX;

  avg_speed_div_client
`ifdef AVG_SPEED_TIMEOUT_EN
    #(.TMO(TMO))
`endif
    u_client (
`ifdef AVG_SPEED_TIMEOUT_EN
    .clk       (clk),
    .r         (r),
`endif
    .state_i   (state_q),
    .zero_i    (dvs_q == '0),
    .div_busy  (div_busy),
    .div_ready (div_ready),
    .div_start (div_start),
    .done_o    (done),
    .tmo_o     (tmo)
  );

`ifdef AVG_SPEED_TIMEOUT_EN
  logic tmo_q;
  assign tmo_err = tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qdvd_q  <= '0;
      qdvs_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef AVG_SPEED_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            dvd_q   <= dividend_d;
            dvs_q   <= trip_time;
            state_q <= (trip_time == '0) ? DONE : LAUNCH;
          end
        end
        LAUNCH, WAIT: begin
          if (acc) begin
            pend_q <= 1'b1;
            qdvd_q <= dividend_d;
            qdvs_q <= trip_time;
          end
          if (state_q == LAUNCH) begin
            if (dvs_q == '0) state_q <= DONE;
            else if (div_start) state_q <= WAIT;
          end else if (done || tmo) begin
            // Divider results register on entry to DONE so valid lands the cycle after div_ready.
            state_q <= DONE;
            valid_q <= 1'b1;
            zero_q  <= 1'b0;
            sat_q   <= done && quot_sat;
            if (done) out_q <= quot_sat ? '1 : div_quot[WO-1:0];
`ifdef AVG_SPEED_TIMEOUT_EN
            tmo_q   <= tmo;
`endif
          end
        end
        DONE: begin
          // Only a zero-time request reaches DONE with a zero divisor; its result registers here.
          if (dvs_q == '0) begin
            valid_q <= 1'b1;
            out_q   <= '0;
            sat_q   <= 1'b0;
            zero_q  <= 1'b1;
`ifdef AVG_SPEED_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
          end
          if (acc) begin
            dvd_q   <= dividend_d;
            dvs_q   <= trip_time;
            pend_q  <= 1'b0;
            state_q <= LAUNCH;
          end else if (pend_q) begin
            dvd_q   <= qdvd_q;
            dvs_q   <= qdvs_q;
            pend_q  <= 1'b0;
            state_q <= LAUNCH;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out          = out_q;
  assign valid        = valid_q;
  assign sat          = sat_q;
  assign zero_t       = zero_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
endmodule

// File: tb/tb_avg_speed_calc.sv
// Directed bench for avg_speed_calc: hand-computed quotients, bench-driven divider handshake.
module tb_avg_speed_calc;
  logic        clk = 1'b0;
  logic        r, en, get, div_busy, div_ready;
  logic [15:0] trip_time, trip_distance;
  logic [11:0] out;
  logic        valid, sat, zero_t, div_start;
  logic [31:0] div_quot, div_dividend;
  logic [15:0] div_divisor;
`ifdef AVG_SPEED_TIMEOUT_EN
  logic        tmo_err;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avg_speed_calc dut (
    .clk(clk), .r(r), .en(en), .get(get),
    .trip_time(trip_time), .trip_distance(trip_distance),
    .out(out), .valid(valid), .sat(sat), .zero_t(zero_t),
    .div_busy(div_busy), .div_ready(div_ready), .div_quot(div_quot),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor)
`ifdef AVG_SPEED_TIMEOUT_EN
    , .tmo_err(tmo_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request and answers it with quotient q; returns in the cycle valid is due.
  task automatic run_one(input logic [15:0] d, input logic [15:0] t, input logic [31:0] q);
    trip_distance = d; trip_time = t; get = 1'b1;
    tick; get = 1'b0;
    tick; div_ready = 1'b1; div_quot = q;
    tick; div_ready = 1'b0;
  endtask

  task automatic test_reset;
    r = 1'b1; en = 1'b1; get = 1'b0; div_busy = 1'b0; div_ready = 1'b0; div_quot = '0;
    trip_time = '0; trip_distance = '0;
    tick; tick;
    checks++; if (out !== 12'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (sat !== 1'b0 || zero_t !== 1'b0) begin errors++; $display("FAIL reset_flags got sat=%b zero_t=%b exp 0 0", sat, zero_t); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", div_start); end
    checks++; if (div_dividend !== 32'd0 || div_divisor !== 16'd0) begin errors++; $display("FAIL reset_operands got %0d/%0d exp 0/0", div_dividend, div_divisor); end
    r = 1'b0;
  endtask

  task automatic test_basic;
    trip_distance = 16'd100; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL basic_start got %b exp 1", div_start); end
    checks++; if (div_dividend !== 32'd360000) begin errors++; $display("FAIL basic_dividend got %0d exp 360000", div_dividend); end
    checks++; if (div_divisor !== 16'd3600) begin errors++; $display("FAIL basic_divisor got %0d exp 3600", div_divisor); end
    tick;
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL basic_start_pulse got %b exp 0", div_start); end
    div_ready = 1'b1; div_quot = 32'd100;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd100) begin errors++; $display("FAIL basic_result got valid=%b out=%0d exp 1 100", valid, out); end
    checks++; if (sat !== 1'b0 || zero_t !== 1'b0) begin errors++; $display("FAIL basic_flags got sat=%b zero_t=%b exp 0 0", sat, zero_t); end
    tick;
    checks++; if (valid !== 1'b0 || out !== 12'd100) begin errors++; $display("FAIL basic_hold got valid=%b out=%0d exp 0 100", valid, out); end
  endtask

  task automatic test_zero_time;
    trip_distance = 16'd50; trip_time = 16'd0; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_start !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL zero_c1 got start=%b valid=%b exp 0 0", div_start, valid); end
    tick;
    checks++; if (valid !== 1'b1 || out !== 12'd0 || zero_t !== 1'b1 || sat !== 1'b0) begin errors++; $display("FAIL zero_result got valid=%b out=%0d zero_t=%b sat=%b exp 1 0 1 0", valid, out, zero_t, sat); end
    tick;
    checks++; if (valid !== 1'b0 || zero_t !== 1'b1 || div_start !== 1'b0) begin errors++; $display("FAIL zero_sticky got valid=%b zero_t=%b start=%b exp 0 1 0", valid, zero_t, div_start); end
  endtask

  task automatic test_saturate;
    trip_distance = 16'd5000; trip_time = 16'd1; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_dividend !== 32'd18000000 || div_divisor !== 16'd1) begin errors++; $display("FAIL sat_operands got %0d/%0d exp 18000000/1", div_dividend, div_divisor); end
    tick; div_ready = 1'b1; div_quot = 32'd18000000;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd4095 || sat !== 1'b1 || zero_t !== 1'b0) begin errors++; $display("FAIL sat_big got valid=%b out=%0d sat=%b zero_t=%b exp 1 4095 1 0", valid, out, sat, zero_t); end
    tick;
    run_one(16'd4095, 16'd3600, 32'd4095);
    checks++; if (valid !== 1'b1 || out !== 12'd4095 || sat !== 1'b0) begin errors++; $display("FAIL sat_edge_4095 got valid=%b out=%0d sat=%b exp 1 4095 0", valid, out, sat); end
    tick;
    run_one(16'd4096, 16'd3600, 32'd4096);
    checks++; if (valid !== 1'b1 || out !== 12'd4095 || sat !== 1'b1) begin errors++; $display("FAIL sat_edge_4096 got valid=%b out=%0d sat=%b exp 1 4095 1", valid, out, sat); end
    tick;
  endtask

  task automatic test_busy;
    div_busy = 1'b1;
    trip_distance = 16'd300; trip_time = 16'd1800; get = 1'b1;
    tick; get = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL busy_hold_%0d got %b exp 0", i, div_start); end
      tick;
    end
    div_busy = 1'b0; div_ready = 1'b1; div_quot = 32'd7;
    #1;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL busy_release got %b exp 1", div_start); end
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL busy_early_ready got valid=%b start=%b exp 0 0", valid, div_start); end
    checks++; if (div_dividend !== 32'd1080000 || div_divisor !== 16'd1800) begin errors++; $display("FAIL busy_operands got %0d/%0d exp 1080000/1800", div_dividend, div_divisor); end
    tick; div_ready = 1'b1; div_quot = 32'd600;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd600) begin errors++; $display("FAIL busy_result got valid=%b out=%0d exp 1 600", valid, out); end
    tick;
  endtask

  task automatic test_queue;
    trip_distance = 16'd100; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0;
    tick;
    trip_distance = 16'd200; trip_time = 16'd7200; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_divisor !== 16'd3600) begin errors++; $display("FAIL queue_active_held got %0d exp 3600", div_divisor); end
    div_ready = 1'b1; div_quot = 32'd100;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd100) begin errors++; $display("FAIL queue_first got valid=%b out=%0d exp 1 100", valid, out); end
    tick;
    checks++; if (valid !== 1'b0 || div_start !== 1'b1) begin errors++; $display("FAIL queue_launch got valid=%b start=%b exp 0 1", valid, div_start); end
    checks++; if (div_dividend !== 32'd720000 || div_divisor !== 16'd7200) begin errors++; $display("FAIL queue_operands got %0d/%0d exp 720000/7200", div_dividend, div_divisor); end
    tick; div_ready = 1'b1; div_quot = 32'd100;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd100) begin errors++; $display("FAIL queue_second got valid=%b out=%0d exp 1 100", valid, out); end
    tick;
    checks++; if (valid !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL queue_drained got valid=%b start=%b exp 0 0", valid, div_start); end
  endtask

  task automatic test_done_get;
    run_one(16'd100, 16'd3600, 32'd100);
    trip_distance = 16'd50; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_start !== 1'b1 || div_dividend !== 32'd180000) begin errors++; $display("FAIL done_get_launch got start=%b dividend=%0d exp 1 180000", div_start, div_dividend); end
    tick; div_ready = 1'b1; div_quot = 32'd50;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd50) begin errors++; $display("FAIL done_get_result got valid=%b out=%0d exp 1 50", valid, out); end
    tick;
  endtask

  task automatic test_enable;
    en = 1'b0; trip_distance = 16'd10; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0;
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL en_ignored_start got %b exp 0", div_start); end
    tick; tick;
    checks++; if (valid !== 1'b0 || out !== 12'd50) begin errors++; $display("FAIL en_ignored_out got valid=%b out=%0d exp 0 50", valid, out); end
    en = 1'b1; get = 1'b1;
    tick; get = 1'b0; en = 1'b0;
    tick; div_ready = 1'b1; div_quot = 32'd10;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b1 || out !== 12'd10) begin errors++; $display("FAIL en_inflight got valid=%b out=%0d exp 1 10", valid, out); end
    en = 1'b1;
    tick;
  endtask

  task automatic test_reset_abort;
    trip_distance = 16'd100; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0;
    tick; r = 1'b1;
    tick; r = 1'b0; div_ready = 1'b1; div_quot = 32'd100;
    tick; div_ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
    tick;
    checks++; if (valid !== 1'b0 || out !== 12'd0 || sat !== 1'b0 || zero_t !== 1'b0) begin errors++; $display("FAIL abort_outputs got valid=%b out=%0d sat=%b zero_t=%b exp 0 0 0 0", valid, out, sat, zero_t); end
    checks++; if (div_start !== 1'b0 || div_dividend !== 32'd0 || div_divisor !== 16'd0) begin errors++; $display("FAIL abort_div got start=%b %0d/%0d exp 0 0/0", div_start, div_dividend, div_divisor); end
  endtask

`ifdef AVG_SPEED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    trip_distance = 16'd100; trip_time = 16'd3600; get = 1'b1;
    tick; get = 1'b0; n = 1;
    while (valid !== 1'b1 && n < 300) begin
      tick; n++;
    end
    checks++; if (valid !== 1'b1 || n != 257) begin errors++; $display("FAIL tmo_latency got valid=%b cycle=%0d exp 1 257", valid, n); end
    checks++; if (tmo_err !== 1'b1 || out !== 12'd0 || sat !== 1'b0 || zero_t !== 1'b0) begin errors++; $display("FAIL tmo_flags got tmo_err=%b out=%0d sat=%b zero_t=%b exp 1 0 0 0", tmo_err, out, sat, zero_t); end
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_zero_time;
    test_saturate;
    test_busy;
    test_queue;
    test_done_get;
    test_enable;
    test_reset_abort;
`ifdef AVG_SPEED_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
